ramp_sequencer: RTL and testbench
=================================

# ramp_sequencer

Sequences the DAC amplitude envelope for one output channel. Takes the DDS phase stream and software start/stop/abort commands, and drives a 16-bit ramp factor (0…8191 = 0…1.0) into the channel multiplier. Ramp-up and ramp-down are aligned to phase-wrap boundaries and last 2^k signal periods. An optional automatic active duration is supported. The block sits between the register bank and the DAC scaling stage and replaces the fixed one-period envelope.

## Interface
- RAMP_LOG2_MAX, 7: maximum supported ramp length exponent.
- CNT_W, 32: width of the active-period counter.
- clk  in  1  system clock.
- aresetn  in  1  reset; synchronous, active-low.
- s_axis_tdata_phase  in  48  DDS phase; bits [47:35] are the 13-bit phase.
- s_axis_tvalid_phase  in  1  phase valid.
- cfg_enable_ramping  in  1  0 = bypass (hard on/off at wraps); latched at start.
- cfg_ramp_log2  in  3  ramp length = 2^k periods, k ≤ RAMP_LOG2_MAX; latched at start.
- cfg_active_periods  in  CNT_W  periods held at full scale; 0 = until stop; latched at start.
- cmd_start  in  1  single-cycle pulse.
- cmd_stop  in  1  single-cycle pulse; requests ramp-down.
- cmd_abort  in  1  single-cycle pulse; forces output to 0 immediately.
- ramp  out  16  envelope factor, 0…8191, registered.
- state  out  3  current FSM state.
- busy  out  1  high when state is neither IDLE nor DONE.
- done  out  1  sticky; set on entry to DONE, cleared by cmd_start.

## Operation
- Phase stage:
  - On tvalid, capture phase = tdata[47:35].
  - wrap = tvalid && phase_new < phase_prev.
  - phase_prev resets to 0; no wrap is generated while tvalid is low.
- The FSM advances only on wrap unless stated otherwise:
  - IDLE → WAIT_SYNC on cmd_start; latch config; clear done, pending_stop, cnt.
  - WAIT_SYNC → RAMP_UP on wrap; cnt=0.
  - RAMP_UP: on wrap, cnt++. When cnt == 2^k−1 at a wrap, go to ACTIVE, or to WAIT_DOWN if pending_stop is set.
  - ACTIVE: on wrap, act_cnt++. When cfg_active_periods ≠ 0 and act_cnt+1 == cfg_active_periods, go directly to RAMP_DOWN with cnt=0. cmd_stop → WAIT_DOWN.
  - WAIT_DOWN → RAMP_DOWN on wrap; cnt=0.
  - RAMP_DOWN: on wrap, cnt++. When cnt == 2^k−1 at a wrap, go to DONE.
  - DONE → WAIT_SYNC on cmd_start, same latching as from IDLE.
- Envelope:
  - up_val = ((cnt << 13) | phase) >> k, a 13-bit result; full width before the shift is 13+RAMP_LOG2_MAX bits.
  - RAMP_UP outputs up_val. RAMP_DOWN outputs 8191 − up_val. ACTIVE and WAIT_DOWN output 8191. IDLE, WAIT_SYNC and DONE output 0.
  - Bypass (latched enable = 0): 8191 in RAMP_UP/ACTIVE/WAIT_DOWN/RAMP_DOWN; 0 elsewhere.
  - Upper 3 bits of ramp are always 0.
- Command rules:
  - cmd_start is ignored unless state is IDLE or DONE.
  - cmd_stop is ignored in IDLE and DONE.
  - cmd_stop in WAIT_SYNC or RAMP_UP sets pending_stop.
  - cmd_stop in WAIT_DOWN or RAMP_DOWN has no effect.
  - cmd_abort in any state goes to DONE with ramp = 0 on the next cycle, and sets done.
  - Priority in the same cycle: abort > stop > start.
  - A wrap coinciding with cmd_stop in ACTIVE: the auto-expiry transition wins if it fires; otherwise the stop is taken.
- Config inputs are sampled only at start. Changing them mid-sequence has no effect.

## Timing
- Reset values: state=IDLE, ramp=0, done=0, busy=0, cnt=0, act_cnt=0, pending_stop=0, phase_prev=0.
- Latency: ramp reflects the phase accepted 2 cycles earlier (capture register, then output register).
- State transitions take effect the cycle after the wrap or command. ramp follows with the same 2-cycle alignment relative to phase.
- With k=0 the ramp spans exactly one period.
- Reset mid-sequence returns to IDLE within one cycle, with ramp = 0.

## Structure
- Package ramp_seq_pkg contains:
  - the state enum: IDLE=0, WAIT_SYNC=1, RAMP_UP=2, ACTIVE=3, WAIT_DOWN=4, RAMP_DOWN=5, DONE=6;
  - FULL_SCALE=8191;
  - PHASE_BITS=13;
  - PHASE_MSB=47.
- Sub-module phase_wrap_detector holds the phase capture register, phase_prev and the wrap flag. The FSM and envelope arithmetic stay in the top.

## Test plan
- k=1, enable=1, active=0, sawtooth phase: start, then phase 4096 in RAMP_UP gives ramp 2048 at cnt 0 and 6144 at cnt 1. After the second wrap, ramp holds at 8191.
- From ACTIVE, pulse stop: ramp stays 8191 until the next wrap. In RAMP_DOWN cnt 0, phase 4096 gives 6143. After 2 wraps, state=DONE, ramp=0, done=1.
- cfg_active_periods=3, k=0: exactly 3 wraps at 8191, then one ramp-down period, then DONE without any stop.
- Stop pulsed during RAMP_UP: ramp-up completes, then the FSM passes through WAIT_DOWN. Ramp-down starts one wrap later with no discontinuity (8191 → ~8191).
- Abort during RAMP_UP at ramp≈3000: ramp=0 the next cycle, done=1. Start in the same cycle as abort is ignored. A following start re-enters WAIT_SYNC and clears done.
- tvalid held low for 100 cycles in ACTIVE: no wraps, act_cnt unchanged. Bypass mode with k=3 gives a 0 → 8191 step exactly at the first wrap.

Source files
------------

// File: rtl/ramp_seq_pkg.sv
// Shared types and constants for the amplitude ramp sequencer.
package ramp_seq_pkg;

  localparam int unsigned PHASE_BITS = 13;
  localparam int unsigned PHASE_MSB  = 47;
  localparam int unsigned DATA_W     = 48;
  localparam int unsigned RAMP_W     = 16;
  localparam int unsigned FULL_SCALE = 8191;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    RAMP_UP   = 3'd2,
    ACTIVE    = 3'd3,
    WAIT_DOWN = 3'd4,
    RAMP_DOWN = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/ramp_sequencer_phase_wrap_detector.sv
// Captures the DDS phase and flags the sample on which the phase wraps.
module phase_wrap_detector
  import ramp_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_W-1:0]     tdata,
  input  logic                  tvalid,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  wrap_c
);

  logic [PHASE_BITS-1:0] phase_new;
  logic                  low_unused;

  assign phase_new  = tdata[PHASE_MSB -: PHASE_BITS];
  assign low_unused = ^tdata[PHASE_MSB-PHASE_BITS:0];

  // The held phase doubles as phase_prev for the wrap comparison.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      phase <= '0;
    end else if (tvalid) begin
      phase <= phase_new;
    end
  end

  assign wrap_c = tvalid && (phase_new < phase);

endmodule

// File: rtl/ramp_sequencer.sv
// Phase-aligned amplitude envelope sequencer for one DAC channel.
module ramp_sequencer
  import ramp_seq_pkg::*;
#(
  parameter int unsigned RAMP_LOG2_MAX = 7,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [DATA_W-1:0]  s_axis_tdata_phase,
  input  logic               s_axis_tvalid_phase,
  input  logic               cfg_enable_ramping,
  input  logic [2:0]         cfg_ramp_log2,
  input  logic [CNT_W-1:0]   cfg_active_periods,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cmd_abort,
  output logic [RAMP_W-1:0]  ramp,
  output logic [2:0]         state,
  output logic               busy,
  output logic               done
);

  localparam int unsigned UP_W  = PHASE_BITS + RAMP_LOG2_MAX;
  localparam logic [2:0]  K_MAX = 3'(RAMP_LOG2_MAX);
  localparam logic [PHASE_BITS-1:0] FULL = PHASE_BITS'(FULL_SCALE);

  state_t                   st;
  logic [RAMP_LOG2_MAX-1:0] cnt;
  logic [CNT_W-1:0]         act_cnt;
  logic [CNT_W-1:0]         lat_active;
  logic [2:0]               lat_k;
  logic                     lat_en;
  logic                     pending_stop;

  logic [PHASE_BITS-1:0]    phase;
  logic                     wrap_c;
  logic [UP_W-1:0]          up_full;
  logic [PHASE_BITS-1:0]    up_val;
  logic [PHASE_BITS-1:0]    env;
  logic                     up_unused;
  logic                     cnt_last;
  logic                     expire;

  phase_wrap_detector u_wrap (
    .clk    (clk),
    .aresetn(aresetn),
    .tdata  (s_axis_tdata_phase),
    .tvalid (s_axis_tvalid_phase),
    .phase  (phase),
    .wrap_c (wrap_c)
  );

  // Ramp position within the 2^k-period ramp, scaled to 13 bits.
  assign up_full   = {cnt, phase} >> lat_k;
  assign up_val    = up_full[PHASE_BITS-1:0];
  assign up_unused = |up_full[UP_W-1:PHASE_BITS];
  assign cnt_last  = (cnt == RAMP_LOG2_MAX'((32'd1 << lat_k) - 32'd1));
  assign expire    = (lat_active != '0) && (CNT_W'(act_cnt + CNT_W'(1)) == lat_active);
  assign state     = st;

  always_comb begin
    env = '0;
    case (st)
      RAMP_UP:           env = lat_en ? up_val : FULL;
      ACTIVE, WAIT_DOWN: env = FULL;
      RAMP_DOWN:         env = lat_en ? (FULL - up_val) : FULL;
      default:           env = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      st           <= IDLE;
      cnt          <= '0;
      act_cnt      <= '0;
      lat_active   <= '0;
      lat_k        <= '0;
      lat_en       <= 1'b0;
      pending_stop <= 1'b0;
      ramp         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ramp <= RAMP_W'(env);
      if (cmd_abort) begin
        // Abort overrides everything and silences the output immediately.
        st           <= DONE;
        done         <= 1'b1;
        busy         <= 1'b0;
        pending_stop <= 1'b0;
        ramp         <= '0;
      end else begin
        case (st)
          IDLE, DONE: begin
            if (cmd_start) begin
              st           <= WAIT_SYNC;
              busy         <= 1'b1;
              done         <= 1'b0;
              pending_stop <= 1'b0;
              cnt          <= '0;
              act_cnt      <= '0;
              lat_en       <= cfg_enable_ramping;
              lat_k        <= (cfg_ramp_log2 > K_MAX) ? K_MAX : cfg_ramp_log2;
              lat_active   <= cfg_active_periods;
            end
          end
          WAIT_SYNC: begin
            if (cmd_stop) pending_stop <= 1'b1;
            if (wrap_c) begin
              st  <= RAMP_UP;
              cnt <= '0;
            end
          end
          RAMP_UP: begin
            if (cmd_stop) pending_stop <= 1'b1;
            if (wrap_c) begin
              if (cnt_last) begin
                cnt <= '0;
                st  <= (pending_stop || cmd_stop) ? WAIT_DOWN : ACTIVE;
              end else begin
                cnt <= cnt + RAMP_LOG2_MAX'(1);
              end
            end
          end
          ACTIVE: begin
            if (wrap_c && expire) begin
              st  <= RAMP_DOWN;
              cnt <= '0;
            end else if (cmd_stop) begin
              st <= WAIT_DOWN;
            end else if (wrap_c) begin
              act_cnt <= act_cnt + CNT_W'(1);
            end
          end
          WAIT_DOWN: begin
            if (wrap_c) begin
              st  <= RAMP_DOWN;
              cnt <= '0;
            end
          end
          RAMP_DOWN: begin
            if (wrap_c) begin
              if (cnt_last) begin
                st   <= DONE;
                done <= 1'b1;
                busy <= 1'b0;
              end else begin
                cnt <= cnt + RAMP_LOG2_MAX'(1);
              end
            end
          end
          default: begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ramp_sequencer.sv
// Self-checking bench for ramp_sequencer: vector table plus model scoreboard.
module tb_ramp_sequencer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [47:0] tdata;
  logic        tvalid;
  logic        cfg_en;
  logic [2:0]  cfg_k;
  logic [31:0] cfg_act;
  logic        start, stop, abort;
  logic [15:0] ramp;
  logic [2:0]  state;
  logic        busy, done;

  always #5 clk = ~clk;

  ramp_sequencer dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .s_axis_tdata_phase (tdata),
    .s_axis_tvalid_phase(tvalid),
    .cfg_enable_ramping (cfg_en),
    .cfg_ramp_log2      (cfg_k),
    .cfg_active_periods (cfg_act),
    .cmd_start          (start),
    .cmd_stop           (stop),
    .cmd_abort          (abort),
    .ramp               (ramp),
    .state              (state),
    .busy               (busy),
    .done               (done)
  );

  int nvec = 0;
  int nmis = 0;
  int state_cycles[8];

  typedef struct {int ramp; int st; int done;} exp_t;
  exp_t sb[$];

  typedef struct {int ph; bit v; bit s; bit p; bit a; int e_ramp; int e_st;} vec_t;
  vec_t tbl[19];

  // Reference model state (registered view as seen after each edge)
  int m_st, m_cnt, m_act, m_pend, m_ph, m_done, m_en, m_k, m_actcfg;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int env(input int st, input int cnt, input int ph, input int en, input int k);
    int up;
    up = (cnt * 8192 + ph) / (1 << k);
    if (en == 0) return (st >= 2 && st <= 5) ? 8191 : 0;
    case (st)
      2:       return up;
      3, 4:    return 8191;
      5:       return 8191 - up;
      default: return 0;
    endcase
  endfunction

  task automatic model(input int ph, input bit v, input bit s, input bit p, input bit a, input bit rn);
    exp_t e;
    bit wrap, last;
    e.ramp = (!rn || a) ? 0 : env(m_st, m_cnt, m_ph, m_en, m_k);
    if (!rn) begin
      m_st = 0; m_cnt = 0; m_act = 0; m_pend = 0; m_ph = 0; m_done = 0;
    end else begin
      wrap = v && (ph < m_ph);
      if (v) m_ph = ph;
      last = (m_cnt == (1 << m_k) - 1);
      if (a) begin
        m_st = 6; m_done = 1; m_pend = 0;
      end else begin
        case (m_st)
          0, 6: if (s) begin
            m_st = 1; m_done = 0; m_pend = 0; m_cnt = 0; m_act = 0;
            m_en = int'(cfg_en); m_k = int'(cfg_k); m_actcfg = int'(cfg_act);
          end
          1: begin
            if (p) m_pend = 1;
            if (wrap) begin m_st = 2; m_cnt = 0; end
          end
          2: begin
            if (p) m_pend = 1;
            if (wrap) begin
              if (last) begin m_cnt = 0; m_st = m_pend ? 4 : 3; end
              else m_cnt++;
            end
          end
          3: begin
            if (wrap && m_actcfg != 0 && m_act + 1 == m_actcfg) begin m_st = 5; m_cnt = 0; end
            else if (p) m_st = 4;
            else if (wrap) m_act++;
          end
          4: if (wrap) begin m_st = 5; m_cnt = 0; end
          5: if (wrap) begin
            if (last) begin m_st = 6; m_done = 1; end
            else m_cnt++;
          end
          default: m_st = 0;
        endcase
      end
    end
    e.st = m_st;
    e.done = m_done;
    sb.push_back(e);
  endtask

  // One clock: drive at negedge, predict, compare just after the posedge.
  task automatic cyc(input int ph, input bit v, input bit s, input bit p, input bit a, input bit rn);
    exp_t e;
    @(negedge clk);
    aresetn = rn;
    tdata   = {13'(ph), 35'($urandom)};
    tvalid  = v;
    start   = s;
    stop    = p;
    abort   = a;
    model(ph, v, s, p, a, rn);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("ramp", int'(ramp), e.ramp);
      check("state", int'(state), e.st);
      check("done", int'(done), e.done);
      check("busy", int'(busy), (e.st != 0 && e.st != 6) ? 1 : 0);
    end
    state_cycles[state]++;
  endtask

  task automatic saw(input int periods, input int step);
    for (int p = 0; p < periods; p++)
      for (int ph = 0; ph < 8192; ph += step)
        cyc(ph, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) state_cycles[i] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph_acc;
    bit found;
    aresetn = 1'b0; tdata = '0; tvalid = 1'b0;
    start = 1'b0; stop = 1'b0; abort = 1'b0;
    cfg_en = 1'b1; cfg_k = 3'd1; cfg_act = 32'd0;
    m_en = 1; m_k = 0; m_actcfg = 0;

    tbl[0]  = '{1000, 1, 1, 0, 0, 0,    1};
    tbl[1]  = '{5000, 1, 0, 0, 0, 0,    1};
    tbl[2]  = '{100,  1, 0, 0, 0, 0,    2};
    tbl[3]  = '{4096, 1, 0, 0, 0, 50,   2};
    tbl[4]  = '{8000, 1, 0, 0, 0, 2048, 2};
    tbl[5]  = '{10,   1, 0, 0, 0, 4000, 2};
    tbl[6]  = '{4096, 1, 0, 0, 0, 4101, 2};
    tbl[7]  = '{8191, 1, 0, 0, 0, 6144, 2};
    tbl[8]  = '{0,    1, 0, 0, 0, 8191, 3};
    tbl[9]  = '{4096, 1, 0, 0, 0, 8191, 3};
    tbl[10] = '{8000, 1, 0, 1, 0, 8191, 4};
    tbl[11] = '{200,  1, 0, 0, 0, 8191, 5};
    tbl[12] = '{4096, 1, 0, 0, 0, 8091, 5};
    tbl[13] = '{8100, 1, 0, 0, 0, 6143, 5};
    tbl[14] = '{50,   1, 0, 0, 0, 4141, 5};
    tbl[15] = '{4096, 1, 0, 0, 0, 4070, 5};
    tbl[16] = '{8191, 1, 0, 0, 0, 2047, 5};
    tbl[17] = '{1,    1, 0, 0, 0, 0,    6};
    tbl[18] = '{100,  0, 0, 0, 0, 0,    6};

    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // k=1 ramp up, hold, stop, ramp down
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].ph, tbl[i].v, tbl[i].s, tbl[i].p, tbl[i].a, 1'b1);
      check($sformatf("tbl%0d_ramp", i), int'(ramp), tbl[i].e_ramp);
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].e_st);
    end
    check("tbl_done", int'(done), 1);

    // Auto-expiry after 3 active periods, k=0; config changed mid-run
    cfg_act = 32'd3; cfg_k = 3'd0;
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cfg_k = 3'd3; cfg_act = 32'd0;
    clear_counts();
    saw(7, 1024);
    check("auto_active_cycles", state_cycles[3], 24);
    check("auto_final_state", int'(state), 6);

    // Stop during ramp-up passes through WAIT_DOWN for one period
    cfg_k = 3'd2; cfg_act = 32'd0; cfg_en = 1'b1;
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    saw(2, 1024);
    cyc(4096, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    clear_counts();
    saw(12, 1024);
    check("pend_wait_down_cycles", state_cycles[4], 8);
    check("pend_active_cycles", state_cycles[3], 0);
    check("pend_final_state", int'(state), 6);

    // Abort mid ramp-up, start in same cycle ignored
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    ph_acc = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      ph_acc = (i * 512) % 8192;
      cyc(ph_acc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (state == 3'd2 && ramp >= 16'd3000) found = 1'b1;
    end
    check("abort_reach_3000", int'(found), 1);
    cyc((ph_acc + 512) % 8192, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("abort_ramp", int'(ramp), 0);
    check("abort_state", int'(state), 6);
    check("abort_done", int'(done), 1);
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("restart_state", int'(state), 1);
    check("restart_done", int'(done), 0);

    // tvalid low in ACTIVE does not advance the active counter
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cfg_k = 3'd0; cfg_act = 32'd2;
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    saw(3, 1024);
    for (int i = 0; i < 100; i++) cyc(int'($urandom_range(0, 8191)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("novalid_state", int'(state), 3);
    saw(1, 1024);
    check("novalid_still_active", int'(state), 3);
    saw(2, 1024);
    check("novalid_final_state", int'(state), 6);

    // Bypass with k=3: hard step at the first wrap
    cfg_en = 1'b0; cfg_k = 3'd3; cfg_act = 32'd0;
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    saw(1, 1024);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bypass_pre_step", int'(ramp), 0);
    cyc(1024, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bypass_step", int'(ramp), 8191);
    saw(10, 1024);
    cyc(512, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    saw(10, 1024);
    check("bypass_final_state", int'(state), 6);

    // Reset mid-sequence
    cfg_en = 1'b1; cfg_k = 3'd1;
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    saw(2, 1024);
    cyc(2048, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midreset_state", int'(state), 0);
    check("midreset_ramp", int'(ramp), 0);

    // Random commands, config and phase steps
    ph_acc = 0;
    for (int i = 0; i < 600; i++) begin
      cfg_en  = 1'($urandom_range(0, 3) != 0);
      cfg_k   = 3'($urandom_range(0, 2));
      cfg_act = 32'($urandom_range(0, 3));
      ph_acc  = (ph_acc + int'($urandom_range(300, 2500))) % 8192;
      cyc(ph_acc, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
